// File: rtl/score4_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : score4_pkg
//  Description : Shared board geometry, cell codes, FSM states and helpers
//                for the Score-4 game datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package score4_pkg;

   localparam int COLS      = 7;
   localparam int ROWS      = 6;
   localparam int MAX_MOVES = COLS * ROWS;

   // Cell occupancy codes; the piece code of player t is {t, ~t}
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      P0    = 2'b01,
      P1    = 2'b10
   } cell_t;

   // panel[col][row], row 0 is the top of the board
   typedef logic [COLS-1:0][ROWS-1:0][1:0] panel_t;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FALL      = 3'd1,
      S_CHECK     = 3'd2,
      S_GAME_OVER = 3'd3,
      S_DRAW      = 3'd4
   } state_t;

   // Cell code for the piece of the given player
   function automatic logic [1:0] piece_of(input logic t);
      return {t, ~t};
   endfunction

endpackage
`default_nettype wire

// File: rtl/move_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : move_controller
//  Description : Owns the Score-4 board. Moves the column cursor, drops a
//                piece with a timed fall animation, toggles the turn on
//                landing and samples the sibling win checker one cycle later
//                to decide win, draw or next move.
//  Revision    : 1.0  initial release
// ============================================================================
module move_controller
   import score4_pkg::*;
#(
   parameter int FALL_DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       left,
   input  logic       right,
   input  logic       put,
   input  logic       exists_i,
   input  logic       winner_i,
   output panel_t     panel,
   output logic       turn,
   output logic [2:0] cursor,
   output logic       illegal,
   output logic       game_over,
   output logic       winner,
   output logic       draw
);

   localparam int               CNT_W       = $clog2(FALL_DIV + 1);
   localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(FALL_DIV - 1);
   localparam logic [5:0]       C_MAX_MOVES = 6'(MAX_MOVES);
   localparam logic [2:0]       C_LAST_COL  = 3'(COLS - 1);
   localparam logic [2:0]       C_LAST_ROW  = 3'(ROWS - 1);

   state_t           r_state,     w_state;
   panel_t           r_panel,     w_panel;
   logic             r_turn,      w_turn;
   logic [2:0]       r_cursor,    w_cursor;
   logic             r_illegal,   w_illegal;
   logic             r_game_over, w_game_over;
   logic             r_winner,    w_winner;
   logic             r_draw,      w_draw;
   logic [2:0]       r_col,       w_col;
   logic [2:0]       r_row,       w_row;
   logic [CNT_W-1:0] r_cnt,       w_cnt;
   logic [5:0]       r_moves,     w_moves;
   logic [2:0]       w_row_dn;
   logic             w_step;

   // State and datapath registers; reset discards any piece in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_panel     <= '0;
         r_turn      <= 1'b0;
         r_cursor    <= 3'd0;
         r_illegal   <= 1'b0;
         r_game_over <= 1'b0;
         r_winner    <= 1'b0;
         r_draw      <= 1'b0;
         r_col       <= 3'd0;
         r_row       <= 3'd0;
         r_cnt       <= '0;
         r_moves     <= 6'd0;
      end else begin
         r_state     <= w_state;
         r_panel     <= w_panel;
         r_turn      <= w_turn;
         r_cursor    <= w_cursor;
         r_illegal   <= w_illegal;
         r_game_over <= w_game_over;
         r_winner    <= w_winner;
         r_draw      <= w_draw;
         r_col       <= w_col;
         r_row       <= w_row;
         r_cnt       <= w_cnt;
         r_moves     <= w_moves;
      end
   end

   // Next-state and next-register values for every FSM state
   always_comb begin
      w_state     = r_state;
      w_panel     = r_panel;
      w_turn      = r_turn;
      w_cursor    = r_cursor;
      w_illegal   = 1'b0;
      w_game_over = r_game_over;
      w_winner    = r_winner;
      w_draw      = r_draw;
      w_col       = r_col;
      w_row       = r_row;
      w_cnt       = r_cnt;
      w_moves     = r_moves;
      w_row_dn    = r_row + 3'd1;
      w_step      = (r_cnt == C_CNT_LAST);

      case (r_state)
         S_IDLE: begin
            // put wins over cursor movement; the cursor stays put either way
            if (put) begin
               if (cell_t'(r_panel[r_cursor][0]) != EMPTY) begin
                  w_illegal = 1'b1;
               end else begin
                  w_col                 = r_cursor;
                  w_row                 = 3'd0;
                  w_cnt                 = '0;
                  w_panel[r_cursor][0]  = piece_of(r_turn);
                  w_state               = S_FALL;
               end
            end else if (left && !right) begin
               w_cursor = (r_cursor == 3'd0) ? C_LAST_COL : r_cursor - 3'd1;
            end else if (right && !left) begin
               w_cursor = (r_cursor == C_LAST_COL) ? 3'd0 : r_cursor + 3'd1;
            end
         end

         S_FALL: begin
            // One decision per step period: move down one row, or land
            if (w_step) begin
               w_cnt = '0;
               if ((r_row != C_LAST_ROW) &&
                   (cell_t'(r_panel[r_col][w_row_dn]) == EMPTY)) begin
                  w_panel[r_col][r_row]    = EMPTY;
                  w_panel[r_col][w_row_dn] = piece_of(r_turn);
                  w_row                    = w_row_dn;
               end else begin
                  w_turn  = ~r_turn;
                  if (r_moves != C_MAX_MOVES) begin
                     w_moves = r_moves + 6'd1;
                  end
                  w_state = S_CHECK;
               end
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end

         S_CHECK: begin
            // Board and turn are stable here, so the win checker has settled
            if (exists_i) begin
               w_game_over = 1'b1;
               w_winner    = winner_i;
               w_state     = S_GAME_OVER;
            end else if (r_moves == C_MAX_MOVES) begin
               w_draw  = 1'b1;
               w_state = S_DRAW;
            end else begin
               w_state = S_IDLE;
            end
         end

         S_GAME_OVER, S_DRAW: begin
            // put starts a fresh game; the last winner id stays latched
            if (put) begin
               w_panel     = '0;
               w_turn      = 1'b0;
               w_cursor    = 3'd0;
               w_moves     = 6'd0;
               w_game_over = 1'b0;
               w_draw      = 1'b0;
               w_state     = S_IDLE;
            end
         end

         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   assign panel     = r_panel;
   assign turn      = r_turn;
   assign cursor    = r_cursor;
   assign illegal   = r_illegal;
   assign game_over = r_game_over;
   assign winner    = r_winner;
   assign draw      = r_draw;

endmodule
`default_nettype wire
